// File: rtl/control_botones_pkg.sv
// control_botones_pkg: test FSM state encoding, selector limit and released reset levels
package control_botones_pkg;
  typedef enum logic [2:0] {T_IDLE, T_HOLD, T_WAIT_REL, T_SELECT, T_COMMIT} t_state_e;
  localparam logic [3:0] SEL_MAX = 4'd9;
  localparam logic BTN_RELEASED = 1'b1;
  localparam logic GIRO_RELEASED = 1'b0;
  localparam int MS_W = 16;
endpackage

// File: rtl/control_botones_antirrebote.sv
// antirrebote: 2-FF sync + debounce + press (1->0) pulse; i_raw in, o_level stable level, o_press one-clock pulse
module antirrebote import control_botones_pkg::*; #(
  parameter int DEB_CYCLES = 50000,
  parameter logic RST_VAL = BTN_RELEASED
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic r_s1, r_s2, r_stable, r_stable_d, r_press;
  logic [CW-1:0] r_cnt;
  logic w_accept;
  assign w_accept = (r_s2 != r_stable) && (r_cnt == CW'(DEB_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_stable <= RST_VAL;
      r_stable_d <= RST_VAL;
      r_press <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      r_cnt <= (r_s2 == r_stable || w_accept) ? '0 : r_cnt + CW'(1);
      r_stable <= w_accept ? r_s2 : r_stable;
      r_stable_d <= r_stable;
      r_press <= r_stable_d & ~r_stable;
    end
  end
  assign o_level = r_stable;
  assign o_press = r_press;
endmodule

// File: rtl/control_botones.sv
// control_botones: debounced command pulses, giro level, long-press test entry and pulseTest selector
module control_botones import control_botones_pkg::*; #(
  parameter int DEB_CYCLES = 50000,
  parameter int TICK_DIV = 50000,
  parameter int LONG_PRESS_MS = 3000,
  parameter int SEL_TIMEOUT_MS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sleep_raw,
  input  logic       btn_awake_raw,
  input  logic       btn_feed_raw,
  input  logic       btn_play_raw,
  input  logic       btn_test_raw,
  input  logic       giro_raw,
  output logic       botonSleep,
  output logic       botonAwake,
  output logic       botonFeed,
  output logic       botonPlay,
  output logic       giro,
  output logic       botonTest,
  output logic [3:0] pulseTest,
  output logic       test_active
);
  localparam int TW = $clog2(TICK_DIV);
  logic [4:0] w_raw, w_lvl, w_press;
  logic w_unused_giro_press, w_tick;
  logic [TW-1:0] r_tick_cnt;
  t_state_e r_state, w_state_n;
  logic [MS_W-1:0] r_hold_ms, w_hold_n, r_idle_ms, w_idle_n;
  logic [3:0] r_sel, w_sel_n;
  logic r_test_active, w_active_n, r_boton_test, w_btest_n;
  assign w_raw = {btn_test_raw, btn_play_raw, btn_feed_raw, btn_awake_raw, btn_sleep_raw};
  for (genvar g = 0; g < 5; g++) begin : g_btn
    antirrebote #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(BTN_RELEASED)) u_deb (
      .clk(clk), .rst(rst), .i_raw(w_raw[g]), .o_level(w_lvl[g]), .o_press(w_press[g]));
  end
  antirrebote #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(GIRO_RELEASED)) u_giro (
    .clk(clk), .rst(rst), .i_raw(giro_raw), .o_level(giro), .o_press(w_unused_giro_press));
  assign w_tick = r_tick_cnt == TW'(TICK_DIV - 1);
  always_comb begin
    w_state_n = r_state;
    w_hold_n = r_hold_ms;
    w_idle_n = r_idle_ms;
    w_sel_n = r_sel;
    w_active_n = r_test_active;
    w_btest_n = 1'b0;
    case (r_state)
      T_IDLE: begin
        if (w_press[4]) begin
          w_state_n = T_HOLD;
          w_hold_n = '0;
        end
      end
      T_HOLD: begin
        if (w_lvl[4]) w_state_n = T_IDLE;
        else if (w_tick) begin
          w_hold_n = r_hold_ms + MS_W'(1);
          if (w_hold_n == MS_W'(LONG_PRESS_MS)) begin
            w_state_n = T_WAIT_REL;
            w_btest_n = 1'b1;
            w_active_n = 1'b1;
          end
        end
      end
      T_WAIT_REL: begin
        if (w_lvl[4]) begin
          w_state_n = T_SELECT;
          w_sel_n = 4'd0;
          w_idle_n = '0;
        end
      end
      T_SELECT: begin
        if (w_press[4]) begin
          w_sel_n = (r_sel == SEL_MAX) ? 4'd1 : r_sel + 4'd1;
          w_idle_n = '0;
        end else if (w_tick) begin
          w_idle_n = r_idle_ms + MS_W'(1);
          if (w_idle_n == MS_W'(SEL_TIMEOUT_MS)) begin
            w_state_n = (r_sel != 4'd0) ? T_COMMIT : T_IDLE;
            w_active_n = 1'b0;
          end
        end
      end
      T_COMMIT: begin
        w_state_n = T_IDLE;
        w_sel_n = 4'd0;
      end
      default: w_state_n = T_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_state <= T_IDLE;
      r_hold_ms <= '0;
      r_idle_ms <= '0;
      r_sel <= 4'd0;
      r_test_active <= 1'b0;
      r_boton_test <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_state <= w_state_n;
      r_hold_ms <= w_hold_n;
      r_idle_ms <= w_idle_n;
      r_sel <= w_sel_n;
      r_test_active <= w_active_n;
      r_boton_test <= w_btest_n;
    end
  end
  assign botonSleep = w_press[0] & ~r_test_active;
  assign botonAwake = w_press[1] & ~r_test_active;
  assign botonFeed = w_press[2] & ~r_test_active;
  assign botonPlay = w_press[3] & ~r_test_active;
  assign botonTest = r_boton_test;
  assign test_active = r_test_active;
  assign pulseTest = (r_state == T_COMMIT) ? r_sel : 4'd0;
endmodule

// File: tb/tb_control_botones.sv
// tb_control_botones: directed self-checking bench for control_botones
module tb_control_botones;
  logic clk = 1'b0, rst = 1'b0;
  logic sleep_r = 1'b1, awake_r = 1'b1, feed_r = 1'b1, play_r = 1'b1, test_r = 1'b1, giro_r = 1'b0;
  logic botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest, test_active;
  logic [3:0] pulseTest;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int n_sleep = 0, n_awake = 0, n_feed = 0, n_play = 0, n_btest = 0, n_pulse = 0;
  int t_sleep = 0, t_awake = 0, t_feed = 0, t_play = 0;
  int t0, s0, s1, pv;
  control_botones #(.DEB_CYCLES(4), .TICK_DIV(10), .LONG_PRESS_MS(5), .SEL_TIMEOUT_MS(8)) dut (
    .clk(clk), .rst(rst),
    .btn_sleep_raw(sleep_r), .btn_awake_raw(awake_r), .btn_feed_raw(feed_r),
    .btn_play_raw(play_r), .btn_test_raw(test_r), .giro_raw(giro_r),
    .botonSleep(botonSleep), .botonAwake(botonAwake), .botonFeed(botonFeed), .botonPlay(botonPlay),
    .giro(giro), .botonTest(botonTest), .pulseTest(pulseTest), .test_active(test_active));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (botonSleep) begin n_sleep++; t_sleep = cyc; end
    if (botonAwake) begin n_awake++; t_awake = cyc; end
    if (botonFeed) begin n_feed++; t_feed = cyc; end
    if (botonPlay) begin n_play++; t_play = cyc; end
    if (botonTest) n_btest++;
    if (pulseTest != 4'd0) n_pulse++;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic short_press();
    test_r = 1'b0; clks(10);
    test_r = 1'b1; clks(10);
  endtask
  task automatic enter_test();
    test_r = 1'b0; clks(80);
    test_r = 1'b1; clks(10);
  endtask
  task automatic wait_pulse(output int v);
    v = 0;
    for (int i = 0; i < 300 && v == 0; i++) begin
      @(negedge clk);
      v = int'(pulseTest);
    end
  endtask
  initial begin
    feed_r = 1'b0;
    clks(3);
    check("rst_outs", int'({botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest, test_active, pulseTest}), 0);
    t0 = cyc; rst = 1'b1;
    clks(12);
    check("feed_cnt", n_feed, 1);
    check("feed_lat", t_feed - t0, 7);
    feed_r = 1'b1; clks(10);
    s0 = n_sleep;
    sleep_r = 1'b0; clks(3); sleep_r = 1'b1; clks(12);
    check("glitch", n_sleep - s0, 0);
    t0 = cyc; sleep_r = 1'b0; clks(20); sleep_r = 1'b1; clks(12);
    check("sleep_cnt", n_sleep - s0, 1);
    check("sleep_lat", t_sleep - t0, 7);
    s0 = n_play; s1 = n_awake;
    t0 = cyc; play_r = 1'b0; awake_r = 1'b0; clks(15); play_r = 1'b1; awake_r = 1'b1; clks(12);
    check("simul_play", n_play - s0, 1);
    check("simul_awake", n_awake - s1, 1);
    check("simul_same", t_play, t_awake);
    check("simul_lat", t_play - t0, 7);
    giro_r = 1'b1; clks(10);
    check("giro_hi", int'(giro), 1);
    s0 = n_btest;
    test_r = 1'b0; clks(80);
    check("btest_cnt", n_btest - s0, 1);
    check("active_on", int'(test_active), 1);
    s1 = n_play;
    play_r = 1'b0; giro_r = 1'b0; clks(10); play_r = 1'b1; clks(10);
    check("play_gated", n_play - s1, 0);
    check("giro_lo", int'(giro), 0);
    test_r = 1'b1; clks(10);
    repeat (3) short_press();
    wait_pulse(pv);
    check("sel3", pv, 3);
    check("active_at_pulse", int'(test_active), 0);
    clks(1);
    check("pulse_width", int'(pulseTest), 0);
    check("btest_once", n_btest - s0, 1);
    enter_test();
    repeat (10) short_press();
    wait_pulse(pv);
    check("sel_wrap", pv, 1);
    enter_test();
    check("abort_pre", int'(test_active), 1);
    s0 = n_pulse;
    clks(120);
    check("abort_active", int'(test_active), 0);
    check("abort_pulse", n_pulse - s0, 0);
    enter_test();
    repeat (2) short_press();
    rst = 1'b0; clks(3); rst = 1'b1;
    check("mid_rst_active", int'(test_active), 0);
    s0 = n_pulse; s1 = n_btest;
    clks(150);
    check("mid_rst_pulse", n_pulse - s0, 0);
    short_press(); clks(100);
    check("after_short_pulse", n_pulse - s0, 0);
    check("after_short_btest", n_btest - s1, 0);
    check("after_short_active", int'(test_active), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/control_botones.md
# control_botones

Button front-end for the pet unit: conditions the raw board buttons and the rotation switch, and produces the command inputs the pet state machine consumes.
- Debounced single-cycle pulses: botonSleep, botonAwake, botonFeed, botonPlay.
- Debounced level: giro.
- Test-mode entry pulse (botonTest) on a long press of the test button.
- 4-bit test selector (pulseTest), built by counting subsequent short presses.

## Interface
- DEB_CYCLES, 50000: consecutive stable clocks required to accept an input change.
- TICK_DIV, 50000: clocks per 1 ms tick.
- LONG_PRESS_MS, 3000: hold time on the test button that triggers test mode.
- SEL_TIMEOUT_MS, 2000: idle time after the last short press that commits the selection.
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-low.
- btn_sleep_raw, btn_awake_raw, btn_feed_raw, btn_play_raw, btn_test_raw  in  1 each  raw pads, active-low (0 = pressed).
- giro_raw  in  1  raw rotation switch, active-high level.
- botonSleep, botonAwake, botonFeed, botonPlay  out  1 each  one-clock pulse per accepted press.
- giro  out  1  debounced switch level.
- botonTest  out  1  one-clock pulse when a long press is recognised.
- pulseTest  out  4  selected test case 1..9; valid for exactly one clock, 0 otherwise.
- test_active  out  1  high from the long-press pulse until commit or abort.

## Operation
- **Input conditioning:** every raw input passes through a 2-FF synchroniser, then a debouncer.
  - The debouncer counter clears whenever the synchronised value equals the stable value.
  - The stable value updates when the counter reaches DEB_CYCLES-1.
- **Pressed condition:** a button is pressed when its stable value is 0. An accepted press is a 1→0 transition of the stable value.
- **Command pulses:** the four command buttons pulse on each accepted press. They are suppressed while test_active=1.
- **Simultaneous presses:** simultaneous accepted presses each pulse in the same clock. No arbitration is done here; the downstream FSM resolves priority.
- **ms tick:** a free-running counter modulo TICK_DIV. The tick is one clock wide.
- **Test FSM states and transitions:**
  - T_IDLE: an accepted test press → T_HOLD and clear hold_ms.
  - T_HOLD: hold_ms increments per tick while the button stays pressed.
    - Release before hold_ms reaches LONG_PRESS_MS → T_IDLE, no output.
    - hold_ms reaches LONG_PRESS_MS → pulse botonTest, set test_active, → T_WAIT_REL.
  - T_WAIT_REL: the button is released → T_SELECT with sel=0 and idle_ms=0. This release is not counted.
  - T_SELECT: each accepted test press increments sel and clears idle_ms. sel wraps 9→1.
    - idle_ms increments per tick.
    - On reaching SEL_TIMEOUT_MS with sel≠0 → T_COMMIT.
    - On reaching SEL_TIMEOUT_MS with sel=0 → abort: clear test_active, → T_IDLE, pulseTest stays 0.
    - A press held past LONG_PRESS_MS in T_SELECT counts as one press only.
  - T_COMMIT: drive pulseTest=sel for one clock, clear test_active and sel, → T_IDLE.
- **giro:** passes through conditioning only and is never suppressed.
- **Reset (rst=0 at a clk edge):**
  - All stable values go to released (buttons 1, giro 0); all counters go to 0; FSM goes to T_IDLE.
  - All outputs go to 0, pulseTest=4'd0.
  - Reset mid-hold or mid-select discards progress without emitting any pulse.

## Timing
- Press latency: a clean raw edge held steady gives its output pulse exactly DEB_CYCLES+3 clocks later (2 sync + DEB_CYCLES + 1 edge register).
- Glitches shorter than DEB_CYCLES clocks produce no output.
- botonTest fires while the button is still held, on the clock after the tick where hold_ms reaches LONG_PRESS_MS.
- pulseTest fires on the clock after the tick where idle_ms reaches SEL_TIMEOUT_MS. test_active falls in the same clock as the pulseTest pulse.
- No two botonTest pulses occur without an intervening commit or abort.

## Structure
- Package control_botones_pkg holds:
  - the FSM state encoding (T_IDLE, T_HOLD, T_WAIT_REL, T_SELECT, T_COMMIT);
  - the maximum selector value 4'd9;
  - the released reset constants.
- Sub-module antirrebote: synchroniser, debouncer and edge detector. Parameter DEB_CYCLES; outputs the stable level plus a press pulse. Instantiated six times.
- The top level holds the tick divider, the test FSM and output gating.

## Test plan
Parameters for all scenarios: DEB_CYCLES=4, TICK_DIV=10, LONG_PRESS_MS=5, SEL_TIMEOUT_MS=8.
- Reset: hold rst=0 for 3 clocks → all outputs 0, pulseTest=0. Release reset with btn_feed_raw held low → botonFeed pulses once, 7 clocks later.
- Glitch: btn_sleep_raw low for 3 clocks → no pulse. Low for 20 clocks → botonSleep high for exactly 1 clock, 7 clocks after the falling edge.
- Simultaneous: btn_play_raw and btn_awake_raw fall in the same clock → botonPlay and botonAwake pulse in the same clock.
- Long press and select:
  - Hold btn_test_raw for 80 clocks → botonTest pulses once and test_active=1.
  - Release, then give 3 short presses → after about 80 clocks idle, pulseTest=4'd3 for 1 clock and test_active=0.
  - During test mode, a btn_play_raw press gives no botonPlay.
- Wrap and abort: 10 short presses in select → pulseTest=4'd1. A separate entry with no presses → timeout, test_active=0, pulseTest never nonzero.
- Mid-operation reset: assert rst during T_SELECT with sel=2 → no pulseTest. A later short test press gives no output.
